// File: rtl/fifo_burst_pkg.sv
// Shared definitions for the FIFO-to-memory burst reader: controller state
// encoding, default parameter values and a small sizing helper.
package fifo_burst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } burst_state_e;

    localparam int DEF_DATA_WIDTH       = 16;
    localparam int DEF_FIFO_DEPTH_WIDTH = 11;
    localparam int DEF_BURST_LEN        = 64;
    localparam int DEF_ADDR_WIDTH       = 24;
    localparam int DEF_FRAME_WORDS      = 307200;

    // Width of the in-burst beat counter; never narrower than one bit.
    function automatic int beat_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/fifo_burst_reader.sv
// Drains a first-word-fall-through FIFO into fixed-length memory write bursts.
// Each burst is announced with a command carrying its start word address; the
// address advances by one burst per burst and wraps to 0 at the end of a frame.
module fifo_burst_reader
    import fifo_burst_pkg::*;
#(
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH_WIDTH = DEF_FIFO_DEPTH_WIDTH,
    parameter int BURST_LEN        = DEF_BURST_LEN,
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int FRAME_WORDS      = DEF_FRAME_WORDS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fifo_empty,
    input  logic [DATA_WIDTH-1:0]       fifo_data,
    input  logic [FIFO_DEPTH_WIDTH-1:0] fifo_count,
    output logic                        fifo_read,
    input  logic                        frame_start,
    output logic                        cmd_valid,
    input  logic                        cmd_ready,
    output logic [ADDR_WIDTH-1:0]       cmd_addr,
    output logic                        wr_valid,
    input  logic                        wr_ready,
    output logic [DATA_WIDTH-1:0]       wr_data,
    output logic                        wr_last,
    output logic                        frame_done,
    output logic                        busy
);

    localparam int BEAT_W = beat_width(BURST_LEN);

    burst_state_e          state_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [BEAT_W-1:0]     beat_r;
    logic                  frame_pending_r;
    logic                  cmd_valid_r;
    logic                  frame_done_r;
    logic                  busy_r;

    logic                  wr_valid_s;
    logic                  fifo_read_s;
    logic                  last_beat_s;
    logic [ADDR_WIDTH:0]   addr_sum_s;
    logic                  wrap_s;
    logic [ADDR_WIDTH-1:0] addr_next_s;

    // Data-phase handshake: beats flow straight from the FIFO head, gated off in reset.
    always_comb begin
        wr_valid_s  = 1'b0;
        fifo_read_s = 1'b0;
        last_beat_s = 1'b0;
        if (!rst && (state_r == ST_DATA)) begin
            wr_valid_s = !fifo_empty;
        end else begin
            wr_valid_s = 1'b0;
        end
        fifo_read_s = wr_valid_s && wr_ready;
        last_beat_s = (beat_r == BEAT_W'(BURST_LEN - 1));
    end

    // Next burst address, wrapping to zero once the frame is fully written.
    always_comb begin
        addr_sum_s  = {1'b0, addr_r} + (ADDR_WIDTH + 1)'(BURST_LEN);
        wrap_s      = (addr_sum_s == (ADDR_WIDTH + 1)'(FRAME_WORDS));
        addr_next_s = {ADDR_WIDTH{1'b0}};
        if (wrap_s) begin
            addr_next_s = {ADDR_WIDTH{1'b0}};
        end else begin
            addr_next_s = addr_sum_s[ADDR_WIDTH-1:0];
        end
    end

    // Burst controller: waits for a full burst in the FIFO, issues the command, streams the beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            addr_r          <= {ADDR_WIDTH{1'b0}};
            beat_r          <= {BEAT_W{1'b0}};
            frame_pending_r <= 1'b0;
            cmd_valid_r     <= 1'b0;
            frame_done_r    <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            // A frame restart is remembered until the controller is idle again.
            if (frame_start) begin
                frame_pending_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (frame_pending_r) begin
                        addr_r <= {ADDR_WIDTH{1'b0}};
                        // A fresh restart arriving now must not be lost.
                        if (!frame_start) begin
                            frame_pending_r <= 1'b0;
                        end
                    end else if (fifo_count >= FIFO_DEPTH_WIDTH'(BURST_LEN)) begin
                        state_r     <= ST_CMD;
                        cmd_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end
                end
                ST_CMD: begin
                    if (cmd_valid_r && cmd_ready) begin
                        state_r     <= ST_DATA;
                        cmd_valid_r <= 1'b0;
                        beat_r      <= {BEAT_W{1'b0}};
                    end
                end
                ST_DATA: begin
                    if (fifo_read_s) begin
                        if (last_beat_s) begin
                            beat_r       <= {BEAT_W{1'b0}};
                            state_r      <= ST_IDLE;
                            busy_r       <= 1'b0;
                            addr_r       <= addr_next_s;
                            frame_done_r <= wrap_s;
                        end else begin
                            beat_r <= beat_r + BEAT_W'(1);
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cmd_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_read  = fifo_read_s;
    assign wr_valid   = wr_valid_s;
    assign wr_data    = fifo_data;
    assign wr_last    = wr_valid_s && last_beat_s;
    assign cmd_valid  = cmd_valid_r && !rst;
    assign cmd_addr   = addr_r;
    assign frame_done = frame_done_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader with a small frame (4-word bursts,
// 16-word frame). A queue-based FIFO feeds the DUT; a word-stream scoreboard
// and an arithmetic address model predict every command and beat.
module tb_fifo_burst_reader;

    localparam int DW  = 16;
    localparam int FDW = 11;
    localparam int BL  = 4;
    localparam int AW  = 24;
    localparam int FW  = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           fifo_empty;
    logic [DW-1:0]  fifo_data;
    logic [FDW-1:0] fifo_count;
    logic           fifo_read;
    logic           frame_start;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [AW-1:0]  cmd_addr;
    logic           wr_valid;
    logic           wr_ready;
    logic [DW-1:0]  wr_data;
    logic           wr_last;
    logic           frame_done;
    logic           busy;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .DATA_WIDTH      (DW),
        .FIFO_DEPTH_WIDTH(FDW),
        .BURST_LEN       (BL),
        .ADDR_WIDTH      (AW),
        .FRAME_WORDS     (FW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_count (fifo_count),
        .fifo_read  (fifo_read),
        .frame_start(frame_start),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_last    (wr_last),
        .frame_done (frame_done),
        .busy       (busy)
    );

    int            checks = 0;
    int            failures = 0;
    int            fd_seen = 0;
    int            fd_expected = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    bit            force_empty;
    logic [AW-1:0] exp_addr;

    logic          s_cmd_valid, s_wr_valid, s_wr_ready, s_wr_last;
    logic          s_frame_done, s_busy, s_fifo_read;
    logic [AW-1:0] s_cmd_addr;
    logic [DW-1:0] s_wr_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = force_empty || (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 16'h0000;
        fifo_count = force_empty ? 11'd0 : FDW'(fifo_q.size());
    endtask

    task automatic push_words(input int n);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = DW'($urandom);
            fifo_q.push_back(w);
            exp_q.push_back(w);
        end
        drive_fifo();
    endtask

    // One clock: sample on the falling edge, check protocol rules, pop on the rising edge.
    task automatic step();
        logic pop;
        @(negedge clk);
        s_cmd_valid  = cmd_valid;
        s_cmd_addr   = cmd_addr;
        s_wr_valid   = wr_valid;
        s_wr_ready   = wr_ready;
        s_wr_data    = wr_data;
        s_wr_last    = wr_last;
        s_frame_done = frame_done;
        s_busy       = busy;
        s_fifo_read  = fifo_read;
        if (s_frame_done) fd_seen++;
        check_eq("read_is_handshake", 32'(fifo_read), 32'(wr_valid && wr_ready));
        check_eq("read_while_empty", 32'(fifo_read && fifo_empty), 32'd0);
        check_eq("valid_while_empty", 32'(wr_valid && fifo_empty), 32'd0);
        pop = fifo_read;
        @(posedge clk);
        #1;
        if (pop && (fifo_q.size() != 0)) void'(fifo_q.pop_front());
        drive_fifo();
    endtask

    task automatic run_burst(input int stall, input int gap_after, input int gap_len,
                             input int fs_beat, input int rst_beat, input bit rnd);
        int            beats;
        int            guard;
        int            gap_left;
        bit            fs_sent;
        bit            wrap;
        logic [DW-1:0] w;
        beats    = 0;
        gap_left = gap_len;
        fs_sent  = 1'b0;
        push_words(BL);
        cmd_ready = (stall == 0);
        wr_ready  = 1'b1;
        for (guard = 0; guard < 30; guard++) begin
            step();
            if (s_cmd_valid) break;
        end
        check_eq("cmd_valid_seen", 32'(s_cmd_valid), 32'd1);
        check_eq("cmd_addr", 32'(s_cmd_addr), 32'(exp_addr));
        if (stall > 0) begin
            for (int i = 1; i < stall; i++) begin
                step();
                check_eq("stall_cmd_valid", 32'(s_cmd_valid), 32'd1);
                check_eq("stall_cmd_addr", 32'(s_cmd_addr), 32'(exp_addr));
                check_eq("stall_no_pop", 32'(s_fifo_read), 32'd0);
            end
            cmd_ready = 1'b1;
            step();
            check_eq("handshake_cmd_valid", 32'(s_cmd_valid), 32'd1);
            check_eq("handshake_cmd_addr", 32'(s_cmd_addr), 32'(exp_addr));
        end
        guard = 0;
        while ((beats < BL) && (guard < 60)) begin
            guard++;
            if (rst_beat == beats) begin
                force_empty = 1'b0;
                drive_fifo();
                rst = 1'b1;
                step();
                check_eq("rst_cmd_valid", 32'(s_cmd_valid), 32'd0);
                check_eq("rst_wr_valid", 32'(s_wr_valid), 32'd0);
                check_eq("rst_fifo_read", 32'(s_fifo_read), 32'd0);
                rst = 1'b0;
                step();
                check_eq("post_rst_busy", 32'(s_busy), 32'd0);
                check_eq("post_rst_cmd_valid", 32'(s_cmd_valid), 32'd0);
                fifo_q.delete();
                exp_q.delete();
                drive_fifo();
                wr_ready = 1'b1;
                exp_addr = '0;
                return;
            end
            force_empty = (beats == gap_after) && (gap_left > 0);
            if (force_empty) gap_left--;
            drive_fifo();
            frame_start = (beats == fs_beat) && !fs_sent;
            if (frame_start) fs_sent = 1'b1;
            wr_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            step();
            frame_start = 1'b0;
            if (force_empty) begin
                check_eq("underrun_wr_valid", 32'(s_wr_valid), 32'd0);
                check_eq("underrun_no_pop", 32'(s_fifo_read), 32'd0);
            end
            if (s_wr_valid) check_eq("wr_last", 32'(s_wr_last), 32'(beats == BL - 1));
            if (s_wr_valid && s_wr_ready) begin
                w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'h0000;
                check_eq("wr_data", 32'(s_wr_data), 32'(w));
                beats++;
            end
        end
        force_empty = 1'b0;
        drive_fifo();
        wr_ready = 1'b1;
        check_eq("beats_done", 32'(beats), 32'(BL));
        wrap = (int'(exp_addr) + BL == FW);
        step();
        check_eq("frame_done", 32'(s_frame_done), 32'(wrap));
        check_eq("busy_after_burst", 32'(s_busy), 32'd0);
        if (wrap) fd_expected++;
        exp_addr = (fs_sent || wrap) ? '0 : exp_addr + AW'(BL);
    endtask

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        cmd_ready   = 1'b1;
        wr_ready    = 1'b1;
        force_empty = 1'b0;
        exp_addr    = '0;
        drive_fifo();
        step();
        step();
        check_eq("reset_busy", 32'(s_busy), 32'd0);
        check_eq("reset_cmd_valid", 32'(s_cmd_valid), 32'd0);
        check_eq("reset_wr_valid", 32'(s_wr_valid), 32'd0);
        check_eq("reset_fifo_read", 32'(s_fifo_read), 32'd0);
        check_eq("reset_frame_done", 32'(s_frame_done), 32'd0);
        rst = 1'b0;
        step();

        // Full frame of four bursts, then the wrapped fifth burst.
        for (int b = 0; b < 5; b++) run_burst(0, -1, 0, -1, -1, 1'b0);
        // Command stalled for five cycles (address 4).
        run_burst(5, -1, 0, -1, -1, 1'b0);
        // Frame restart mid-burst at address 8.
        run_burst(0, -1, 0, 1, -1, 1'b0);
        // FIFO underrun after two beats for three cycles (address 0).
        run_burst(0, 2, 3, -1, -1, 1'b0);
        // Reset mid-burst at beat 2 (address 4), then a clean burst from 0.
        run_burst(0, -1, 0, -1, 2, 1'b0);
        run_burst(0, -1, 0, -1, -1, 1'b0);

        // Randomised bursts with stalls, underruns, restarts and resets.
        for (int b = 0; b < 20; b++) begin
            run_burst($urandom_range(0, 3),
                      $urandom_range(0, 3),
                      $urandom_range(0, 3),
                      ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : -1,
                      ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : -1,
                      1'b1);
        end

        check_eq("frame_done_total", 32'(fd_seen), 32'(fd_expected));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
